imem_prefetch: RTL and testbench
================================

Name: imem_prefetch

Overview:
- Parametrised, writable instruction memory with a registered read port and a small prefetch FIFO.
- Replaces the fixed-program combinational IMEM ROM.
- A loader writes the program while fetch is stopped. In RUN, the block fetches sequential words ahead of the core and hands out {instruction, PC} pairs over a valid/ready handshake.
- A redirect input supports BEQ/BNE/J by flushing the queue and restarting fetch at a new PC.

Parameters:
- ADDR_W, 16, width of PC and load address (word index).
- DATA_W, 32, instruction width.
- DEPTH, 256, number of implemented instruction words; addresses >= DEPTH read as NOP.
- FIFO_DEPTH, 4, prefetch queue entries (power of two, >= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write one word (honoured only in LOAD).
- load_addr  in  ADDR_W  word address for load.
- load_data  in  DATA_W  word to write.
- load_err  out  1  one-cycle pulse: load attempted in RUN.
- start  in  1  LOAD->RUN, begin fetch at start_pc.
- start_pc  in  ADDR_W  initial fetch PC.
- halt  in  1  RUN->LOAD, flush queue.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  new fetch PC.
- instr_valid  out  1  head of queue is valid.
- instr_ready  in  1  consumer accepts head.
- instr  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  PC of head instruction.
- busy  out  1  state == RUN.

Behaviour:
- Reset (async, rst=1): state LOAD, fetch_pc 0, queue empty, no read in flight; instr_valid 0, instr 0, instr_pc 0, load_err 0, busy 0. Memory array is not cleared by reset.
- States:
  - LOAD: load_en with load_addr < DEPTH writes mem[load_addr] at the clock edge. Out-of-range load is ignored silently. start (with no halt) -> RUN; fetch_pc <= start_pc.
  - RUN: halt -> LOAD, flushing the queue and in-flight read. halt has priority over redirect. start in RUN is ignored. load_en in RUN does not write and pulses load_err the following cycle.
- Fetch:
  - Memory read is registered; one-cycle latency from issue to queue push.
  - Issue condition: RUN && !redirect && !halt && (count + inflight) < FIFO_DEPTH.
  - On issue, the read uses fetch_pc and fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_W.
  - Read data for address >= DEPTH is 0 (NOP).
  - The push carries the issued PC alongside the data.
- Handshake:
  - The pop happens when instr_valid && instr_ready.
  - instr_valid = (count != 0); instr/instr_pc show the queue head.
  - instr and instr_pc hold stable while instr_valid && !instr_ready.
  - When empty, instr = 0 and instr_pc = 0.
  - Push and pop in the same cycle keep count unchanged.
- Redirect (RUN only):
  - On the clock edge the queue is emptied and the in-flight read is discarded (no push); fetch_pc <= redirect_pc.
  - Any pop in that cycle is also lost; the consumer must not rely on it.
  - instr_valid is 0 the cycle after the redirect. The first redirected instruction is valid 2 cycles after the redirect edge.
  - redirect in LOAD is ignored.
- Start latency: instr_valid rises 2 cycles after the start edge (issue at edge+1, push at edge+2).
- Steady state: with instr_ready held 1, one instruction per cycle.
- Full queue: issue stalls; no overwrite and no drop.
- Reset mid-RUN: returns to LOAD immediately; memory contents survive.

Decomposition:
- imem_pkg holds:
  - IMEM_NOP = 32'h0.
  - State encoding: ST_LOAD = 1'b0, ST_RUN = 1'b1.
  - Default parameter constants.
- Sub-module imem_fifo: synchronous FIFO of {ADDR_W+DATA_W}-bit entries. It has push/pop/flush, count, and head outputs, clk/rst with async active-high reset, and depth FIFO_DEPTH.
- The top level holds the memory array, fetch_pc, in-flight flag, FSM and load_err.

Test Plan:
1. Load mem[0..3] = 32'h11, 32'h22, 32'h33, 32'h44; start with start_pc=0, instr_ready=1 -> instr_valid rises 2 cycles after start; instructions appear on consecutive cycles as (0,32'h11), (1,32'h22), (2,32'h33), (3,32'h44).
2. Backpressure: after start, hold instr_ready=0 for 10 cycles -> count saturates at 4, head stays (0,32'h11); release -> (0..7) delivered in order, none lost or duplicated.
3. Redirect: while streaming, assert redirect with redirect_pc=2 at the cycle the head is PC 1 -> instr_valid=0 the next cycle; the next valid outputs are (2,32'h33), then (3,32'h44); no PC 2/3 from before the redirect appears twice.
4. Boundary: DEPTH=256, start_pc=16'hFFFE -> outputs (FFFE,0), (FFFF,0), (0000, mem[0]), showing the wrap and NOP for out-of-range addresses.
5. Load in RUN: load_en=1, load_addr=0, load_data=32'hDEAD during RUN -> load_err pulses one cycle; after halt and restart, PC 0 still reads 32'h11.
6. Async reset mid-stream: assert rst between clock edges -> instr_valid=0 and busy=0 immediately; after release and start_pc=1 -> first output (1,32'h22), showing memory is retained.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the prefetching instruction memory.
// Default sizes match the single-issue core this block feeds.
package imem_pkg;

  localparam int IMEM_ADDR_W_DEF     = 16;
  localparam int IMEM_DATA_W_DEF     = 32;
  localparam int IMEM_DEPTH_DEF      = 256;
  localparam int IMEM_FIFO_DEPTH_DEF = 4;

  localparam logic [31:0] IMEM_NOP = 32'h0;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_fifo.sv
// Synchronous prefetch queue with flush; head reads as zero when empty.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push is dropped only when full without a pop; flush wins over push/pop.
module imem_fifo #(
  parameter  int W     = 48,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             not_empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= push_dat;
  end

  assign head = not_empty ? store[rd_ptr] : '0;

endmodule

// File: rtl/imem_prefetch.sv
// Writable instruction memory with registered read feeding a prefetch queue.
// Latency: first instruction valid 2 cycles after start/redirect, then 1/cycle.
// Backpressure: instr_ready low stalls issue once queue plus in-flight read fill it.
module imem_prefetch
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W_DEF,
  parameter int DATA_W     = IMEM_DATA_W_DEF,
  parameter int DEPTH      = IMEM_DEPTH_DEF,
  parameter int FIFO_DEPTH = IMEM_FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [DATA_W-1:0] mem [DEPTH];

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] rd_pc_q;
  logic [DATA_W-1:0] rd_dat_q;

  logic              issue;
  logic              flush;
  logic              load_wr;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occ;
  logic [ENT_W-1:0]  head;

  // Address range check done one bit wider so DEPTH == 2**ADDR_W still works.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue      = 1'b0;
    flush      = 1'b0;
    load_wr    = 1'b0;
    occ        = count + CNT_W'(inflight_q);
    case (state_q)
      ST_LOAD: begin
        load_wr = load_en && in_range(load_addr);
        if (start && !halt) begin
          state_d    = ST_RUN;
          fetch_pc_d = start_pc;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_LOAD;
          flush   = 1'b1;
        end else if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (occ < CNT_W'(FIFO_DEPTH)) begin
          // Reserving a slot for the in-flight read means a push never meets a full queue.
          issue      = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      load_err   <= (state_q == ST_RUN) && load_en;
    end
  end

  // Array and read register carry no reset so the program survives rst.
  always_ff @(posedge clk) begin
    if (load_wr) mem[load_addr[IDX_W-1:0]] <= load_data;
    if (issue) begin
      rd_pc_q  <= fetch_pc_q;
      rd_dat_q <= in_range(fetch_pc_q) ? mem[fetch_pc_q[IDX_W-1:0]] : DATA_W'(IMEM_NOP);
    end
  end

  assign push = inflight_q && !flush;
  assign pop  = instr_valid && instr_ready;

  imem_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({rd_pc_q, rd_dat_q}),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .head     (head)
  );

  assign instr_valid       = (count != '0);
  assign {instr_pc, instr} = head;
  assign busy              = (state_q == ST_RUN);

endmodule

// File: tb/tb_imem_prefetch.sv
// Directed vector bench for imem_prefetch: load, stream, backpressure, redirect, wrap, reset.
module tb_imem_prefetch;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        load_err;
  logic        start;
  logic [15:0] start_pc;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic [31:0] ei;
  } vec_t;

  vec_t vq[$];

  imem_prefetch dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err),
    .start       (start),
    .start_pc    (start_pc),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic [15:0] rp,
                              input logic ev, input logic [15:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rdy = r; v.redir = rd; v.rpc = rp; v.ev = ev; v.epc = ep; v.ei = ei;
    return v;
  endfunction

  // Each record's inputs are applied for one edge; expectations are the outputs after it.
  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      instr_ready = vq[i].rdy;
      redirect    = vq[i].redir;
      redirect_pc = vq[i].rpc;
      tick();
      chk($sformatf("%s[%0d].valid", tag, i), 64'(instr_valid), 64'(vq[i].ev));
      chk($sformatf("%s[%0d].pc", tag, i), 64'(instr_pc), vq[i].ev ? 64'(vq[i].epc) : 64'h0);
      chk($sformatf("%s[%0d].instr", tag, i), 64'(instr), vq[i].ev ? 64'(vq[i].ei) : 64'h0);
    end
    redirect = 1'b0;
    vq.delete();
  endtask

  task automatic do_start(input logic [15:0] pc, input string tag);
    start    = 1'b1;
    start_pc = pc;
    tick();
    start = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'h1);
    chk({tag, ".valid0"}, 64'(instr_valid), 64'h0);
  endtask

  task automatic do_halt(input string tag);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'h0);
    chk({tag, ".valid"}, 64'(instr_valid), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_pc = '0; halt = 1'b0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    #1;
    chk("rst.valid", 64'(instr_valid), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);
    chk("rst.instr", 64'(instr), 64'h0);
    chk("rst.pc", 64'(instr_pc), 64'h0);
    chk("rst.load_err", 64'(load_err), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Program mem[0..7] = 11,22,..,88; then an out-of-range write that must not alias mem[0].
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 16'(i); load_data = 32'h11 * (i + 1);
      tick();
      chk("load.err", 64'(load_err), 64'h0);
    end
    load_addr = 16'h0100; load_data = 32'hBAD;
    tick();
    load_en = 1'b0;

    // start together with halt in LOAD stays in LOAD
    start = 1'b1; halt = 1'b1;
    tick();
    start = 1'b0; halt = 1'b0;
    chk("starthalt.busy", 64'(busy), 64'h0);

    // 1: streaming with instr_ready held high
    instr_ready = 1'b1;
    do_start(16'h0, "t1");
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(1, 0, 0, 1, 16'(k), 32'h11 * (k + 1)));
    run_vecs("t1");
    do_halt("t1");

    // 2: backpressure for 10 cycles, then drain PCs 1..7 back to back
    instr_ready = 1'b0;
    do_start(16'h0, "t2");
    vq.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 9; k++) vq.push_back(mk(0, 0, 0, 1, 16'h0, 32'h11));
    for (int k = 1; k <= 7; k++) vq.push_back(mk(1, 0, 0, 1, 16'(k), 32'h11 * (k + 1)));
    run_vecs("t2");
    do_halt("t2");

    // 3: redirect to PC 2 while head is PC 1
    instr_ready = 1'b1;
    do_start(16'h0, "t3");
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 16'h0, 32'h11));
    vq.push_back(mk(1, 0, 0, 1, 16'h1, 32'h22));
    vq.push_back(mk(1, 1, 16'h2, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 16'h2, 32'h33));
    vq.push_back(mk(1, 0, 0, 1, 16'h3, 32'h44));
    vq.push_back(mk(1, 0, 0, 1, 16'h4, 32'h55));
    run_vecs("t3");
    // halt beats a simultaneous redirect, and nothing trickles in afterwards
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h6;
    tick();
    halt = 1'b0; redirect = 1'b0;
    chk("t3.hr.busy", 64'(busy), 64'h0);
    chk("t3.hr.valid", 64'(instr_valid), 64'h0);
    tick();
    chk("t3.hr.valid2", 64'(instr_valid), 64'h0);

    // 4: PC wrap through out-of-range NOP region
    do_start(16'hFFFE, "t4");
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 16'hFFFE, 32'h0));
    vq.push_back(mk(1, 0, 0, 1, 16'hFFFF, 32'h0));
    vq.push_back(mk(1, 0, 0, 1, 16'h0000, 32'h11));
    run_vecs("t4");
    do_halt("t4");

    // 5: load attempt while running
    do_start(16'h0, "t5");
    load_en = 1'b1; load_addr = 16'h0; load_data = 32'hDEAD;
    tick();
    load_en = 1'b0;
    chk("t5.err_pulse", 64'(load_err), 64'h1);
    tick();
    chk("t5.err_clear", 64'(load_err), 64'h0);
    do_halt("t5");
    do_start(16'h0, "t5b");
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 16'h0, 32'h11));
    run_vecs("t5b");

    // 6: async reset between edges while streaming
    vq.push_back(mk(1, 0, 0, 1, 16'h1, 32'h22));
    run_vecs("t6a");
    #2;
    rst = 1'b1;
    #1;
    chk("t6.async.valid", 64'(instr_valid), 64'h0);
    chk("t6.async.busy", 64'(busy), 64'h0);
    chk("t6.async.instr", 64'(instr), 64'h0);
    chk("t6.async.pc", 64'(instr_pc), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    // a redirect presented during the LOAD->RUN edge is ignored
    redirect = 1'b1; redirect_pc = 16'h5;
    do_start(16'h1, "t6");
    redirect = 1'b0;
    vq.push_back(mk(1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 16'h1, 32'h22));
    vq.push_back(mk(1, 0, 0, 1, 16'h2, 32'h33));
    run_vecs("t6");
    do_halt("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
